alu_op_sequencer: RTL and testbench

- Initiator side of the 2-bit-opcode, 8-bit ALU operand/result interface.
- Accepts ALU commands through a valid/ready command port and buffers them in a small FIFO.
- Drives registered `op_code`/`a`/`b` into an external combinational ALU (00 add, 01 sub, 10 and, 11 or), one operation at a time.
- Captures the ALU result and returns it with tag and flags through a valid/ready response port.
- Sits between a command producer (test sequencer or datapath controller) and the shared ALU datapath.

---
 rtl/alu_op_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command FIFO plus two-state issue/capture sequencer driving an external ALU
module alu_op_sequencer #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   parameter int TAGW  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [TAGW-1:0]  cmd_tag,
   output logic [1:0]       alu_op_code,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [1:0]       rsp_op,
   output logic [TAGW-1:0]  rsp_tag,
   output logic             rsp_zero,
   output logic [15:0]      issued_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 2 + 2 * WIDTH + TAGW;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic {IDLE, EXEC} state_t;

   state_t           state_q, state_d;
   logic [EW-1:0]    mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic [EW-1:0]    head;
   logic [1:0]       head_op;
   logic [WIDTH-1:0] head_a, head_b;
   logic [TAGW-1:0]  head_tag;
   logic             empty, full, push, pop, load, capture;

   logic [1:0]       alu_op_q;
   logic [WIDTH-1:0] alu_a_q, alu_b_q;
   logic             rsp_valid_q, rsp_zero_q;
   logic [WIDTH-1:0] rsp_result_q;
   logic [1:0]       rsp_op_q;
   logic [TAGW-1:0]  rsp_tag_q;
   logic [15:0]      issued_q;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign cmd_ready = !full;
   assign push = cmd_valid && cmd_ready;
   assign pop  = capture;

   assign head = mem_q[rd_ptr_q[AW-1:0]];
   assign {head_op, head_a, head_b, head_tag} = head;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_a, cmd_b, cmd_tag};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Issue only when the response slot is free or draining this edge,
   // so a capture never collides with an unconsumed response.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty && (!rsp_valid_q || rsp_ready)) begin
               state_d = EXEC;
               load    = 1'b1;
            end
         end
         EXEC: begin
            state_d = IDLE;
            capture = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_op_q <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
      end else if (load) begin
         alu_op_q <= head_op;
         alu_a_q  <= head_a;
         alu_b_q  <= head_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_op_q     <= '0;
         rsp_tag_q    <= '0;
         rsp_zero_q   <= 1'b0;
      end else if (capture) begin
         rsp_valid_q  <= 1'b1;
         rsp_result_q <= alu_result;
         rsp_op_q     <= head_op;
         rsp_tag_q    <= head_tag;
         rsp_zero_q   <= (alu_result == '0);
      end else if (rsp_ready) begin
         rsp_valid_q  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       issued_q <= '0;
      else if (capture) issued_q <= issued_q + 16'd1;
   end

   assign alu_op_code  = alu_op_q;
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_result   = rsp_result_q;
   assign rsp_op       = rsp_op_q;
   assign rsp_tag      = rsp_tag_q;
   assign rsp_zero     = rsp_zero_q;
   assign issued_count = issued_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_a, cmd_b;
   logic [3:0]  cmd_tag;
   logic [1:0]  alu_op_code;
   logic [7:0]  alu_a, alu_b, alu_result;
   logic        rsp_valid, rsp_ready;
   logic [7:0]  rsp_result;
   logic [1:0]  rsp_op;
   logic [3:0]  rsp_tag;
   logic        rsp_zero;
   logic [15:0] issued_count;

   int n_checks = 0;
   int n_fails  = 0;
   int accepted;

   always #5 clk = ~clk;

   alu_op_sequencer #(.DEPTH(4), .WIDTH(8), .TAGW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
      .alu_op_code(alu_op_code), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_tag(rsp_tag), .rsp_zero(rsp_zero),
      .issued_count(issued_count)
   );

   // External combinational ALU
   always_comb begin
      alu_result = 8'h00;
      case (alu_op_code)
         2'b00: alu_result = alu_a + alu_b;
         2'b01: alu_result = alu_a - alu_b;
         2'b10: alu_result = alu_a & alu_b;
         2'b11: alu_result = alu_a | alu_b;
         default: alu_result = 8'h00;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] tag);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
      chk("send_ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag);
      int k = 0;
      while (!rsp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk(tag, {31'd0, rsp_valid}, 32'd1);
   endtask

   task automatic check_rsp(input string tag, input logic [7:0] res, input logic [1:0] op,
                            input logic [3:0] t, input logic z);
      wait_rsp({tag, "_valid"});
      chk({tag, "_result"}, {24'd0, rsp_result}, {24'd0, res});
      chk({tag, "_op"},     {30'd0, rsp_op},     {30'd0, op});
      chk({tag, "_tag"},    {28'd0, rsp_tag},    {28'd0, t});
      chk({tag, "_zero"},   {31'd0, rsp_zero},   {31'd0, z});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_count",     {16'd0, issued_count}, 32'd0);
      chk("rst_alu",       {14'd0, alu_op_code, alu_a, alu_b}, 32'd0);
      chk("rst_rsp_fields", {17'd0, rsp_result, rsp_op, rsp_tag, rsp_zero}, 32'd0);
      rst_n = 1'b1;

      // Single add with exact latency: accept N, alu_* at N+1, rsp_valid at N+2
      send(2'b00, 8'h7F, 8'h01, 4'd3);
      chk("add_lat_n1", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("add_alu_a", {24'd0, alu_a}, 32'h7F);
      chk("add_alu_b", {24'd0, alu_b}, 32'h01);
      chk("add_lat_n2", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("add_lat_valid", {31'd0, rsp_valid}, 32'd1);
      check_rsp("add", 8'h80, 2'b00, 4'd3, 1'b0);
      chk("add_count", {16'd0, issued_count}, 32'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("add_consumed", {31'd0, rsp_valid}, 32'd0);

      // Subtraction wrap and zero flag
      send(2'b01, 8'h00, 8'h01, 4'd5);
      check_rsp("sub_wrap", 8'hFF, 2'b01, 4'd5, 1'b0);
      @(negedge clk);
      send(2'b01, 8'h55, 8'h55, 4'd6);
      check_rsp("sub_zero", 8'h00, 2'b01, 4'd6, 1'b1);
      @(negedge clk);

      // Back-to-back AND / OR, responses two cycles apart
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 8'hF0; cmd_b = 8'h3C; cmd_tag = 4'd1;
      @(negedge clk);
      cmd_op = 2'b11; cmd_a = 8'hF0; cmd_b = 8'h0F; cmd_tag = 4'd2;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check_rsp("mix_and", 8'h30, 2'b10, 4'd1, 1'b0);
      @(negedge clk);
      chk("mix_gap", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      check_rsp("mix_or", 8'hFF, 2'b11, 4'd2, 1'b0);
      chk("mix_count", {16'd0, issued_count}, 32'd5);

      // Backpressure from reset: DEPTH+1 accepted
      rsp_ready = 1'b0;
      do_reset();
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'h10 + 8'(i); cmd_b = 8'h01; cmd_tag = 4'(i);
         if (cmd_ready) accepted++;
         @(negedge clk);
      end
      chk("bp_ready_low", {31'd0, cmd_ready}, 32'd0);
      cmd_valid = 1'b0;
      chk("bp_accepted", accepted, 32'd5);
      check_rsp("bp_hold0", 8'h11, 2'b00, 4'd0, 1'b0);
      repeat (3) @(negedge clk);
      check_rsp("bp_hold1", 8'h11, 2'b00, 4'd0, 1'b0);
      chk("bp_count_held", {16'd0, issued_count}, 32'd1);
      rsp_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         check_rsp($sformatf("bp_r%0d", j), 8'h11 + 8'(j), 2'b00, 4'(j), 1'b0);
         @(negedge clk);
      end
      chk("bp_count", {16'd0, issued_count}, 32'd5);
      chk("bp_drained", {31'd0, rsp_valid}, 32'd0);

      // Reset during EXEC discards the in-flight op
      send(2'b00, 8'h20, 8'h02, 4'd7);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rx_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rx_count", {16'd0, issued_count}, 32'd0);
      chk("rx_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      repeat (3) @(negedge clk);
      chk("rx_no_rsp", {31'd0, rsp_valid}, 32'd0);
      send(2'b01, 8'h10, 8'h03, 4'd9);
      check_rsp("rx_new", 8'h0D, 2'b01, 4'd9, 1'b0);
      chk("rx_new_count", {16'd0, issued_count}, 32'd1);
      @(negedge clk);

      // Counter wrap
      force dut.issued_q = 16'hFFFF;
      @(negedge clk);
      release dut.issued_q;
      @(negedge clk);
      chk("wrap_pre", {16'd0, issued_count}, 32'hFFFF);
      send(2'b11, 8'h00, 8'h00, 4'd4);
      check_rsp("wrap_rsp", 8'h00, 2'b11, 4'd4, 1'b1);
      chk("wrap_count", {16'd0, issued_count}, 32'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
